// File: rtl/addsub_op_sequencer.sv
// rtl/addsub_op_sequencer.sv - request/response sequencer around a 4-bit adder/subtractor
//
// Purpose: accepts one operation per in_valid/in_ready handshake and registers the
// operands and mode onto add_a/add_b/add_mode. It waits one cycle for the external
// combinational adder to settle, captures add_s with derived flags, and presents the
// result under out_valid/out_ready.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    request handshake; in_a, in_b, in_mode carry the request
//   add_a/add_b/add_mode registered operands driven to the adder
//   add_s                5-bit adder result fed back from the adder
//   out_valid/out_ready  result handshake; out_sum/carry/borrow/zero/ovf carry the result
//   op_count             completed handoffs, wraps modulo 2^CNT_W
module addsub_op_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic             in_mode,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_mode,
    input  logic [4:0]       add_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_sum,
    output logic             out_carry,
    output logic             out_borrow,
    output logic             out_zero,
    output logic             out_ovf,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       add_a_q, add_a_d;
    logic [3:0]       add_b_q, add_b_d;
    logic             add_mode_q, add_mode_d;
    logic [3:0]       sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            add_a_q    <= '0;
            add_b_q    <= '0;
            add_mode_q <= 1'b0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            add_mode_q <= add_mode_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        add_mode_d = add_mode_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        borrow_d   = borrow_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    add_a_d    = in_a;
                    add_b_d    = in_b;
                    add_mode_d = in_mode;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                // Operands have been stable for a full cycle, so add_s is settled here.
                sum_d    = add_s[3:0];
                carry_d  = add_s[4];
                borrow_d = add_mode_q & ~add_s[4];
                zero_d   = (add_s[3:0] == 4'd0);
                // Effective B operand sign is b3 flipped when subtracting.
                ovf_d    = (add_a_q[3] == (add_b_q[3] ^ add_mode_q)) &
                           (add_s[3] != add_a_q[3]);
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign add_mode   = add_mode_q;
    assign out_sum    = sum_q;
    assign out_carry  = carry_q;
    assign out_borrow = borrow_q;
    assign out_zero   = zero_q;
    assign out_ovf    = ovf_q;
    assign op_count   = cnt_q;

endmodule
